stage_execution_muldiv_ctrl: RTL and testbench

Iterative RV32M multiply/divide sequencer attached beside the EX-stage ALU. It accepts one M-extension operation from EX and runs a radix-2 shift-add multiply or restoring divide over 32 cycles. While the operation runs it holds the pipeline with o_Stall, then presents a registered 32-bit result for one cycle. It also handles the RV32M divide-by-zero and signed-overflow cases and supports flush from branch/trap redirect.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_datapath.sv | 102 ++++++++++
 rtl/stage_execution_muldiv_ctrl.sv | 79 +++++++
 tb/tb_stage_execution_muldiv_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } MulDivOp_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL   = 3'd2,
        DIV   = 3'd3,
        FIXUP = 3'd4,
        DONE  = 3'd5
    } MulDivState_t;

    localparam int unsigned MULDIV_ITERATIONS = 32;
    localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulators, shift-add / restoring-divide step logic, sign fixup and result register.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_Clock,
    input  logic            i_Reset_n,
    input  logic            i_Load,
    input  logic            i_LoadSpecial,
    input  logic            i_Step,
    input  logic            i_Fixup,
    input  logic [2:0]      i_Funct3,
    input  logic [XLEN-1:0] i_Source1,
    input  logic [XLEN-1:0] i_Source2,
    output logic            o_Special,
    output logic [XLEN-1:0] o_Result
);

    MulDivOp_t         w_Op;
    MulDivOp_t         r_Op;
    logic              w_Signed1, w_Signed2, w_Neg1, w_Neg2;
    logic              w_IsDiv, w_DivZero, w_Overflow;
    logic [XLEN-1:0]   w_Mag1, w_Mag2, w_MinInt;
    logic [2*XLEN:0]   r_Acc, w_AccLoad, w_MulNext, w_DivNext;
    logic [XLEN-1:0]   r_Opnd;
    logic              r_NegQ, r_NegR;
    logic [XLEN:0]     w_MulSum, w_DivDiff;
    logic [2*XLEN-1:0] w_Prod;
    logic [XLEN-1:0]   w_Quo, w_Rem, w_Result, r_Result;

    always_comb begin
        w_Op       = MulDivOp_t'(i_Funct3);
        w_Signed1  = (w_Op == OP_MULH) || (w_Op == OP_MULHSU) || (w_Op == OP_DIV) || (w_Op == OP_REM);
        w_Signed2  = (w_Op == OP_MULH) || (w_Op == OP_DIV) || (w_Op == OP_REM);
        w_Neg1     = w_Signed1 & i_Source1[XLEN-1];
        w_Neg2     = w_Signed2 & i_Source2[XLEN-1];
        w_Mag1     = w_Neg1 ? -i_Source1 : i_Source1;
        w_Mag2     = w_Neg2 ? -i_Source2 : i_Source2;
        w_MinInt   = {1'b1, {(XLEN-1){1'b0}}};
        w_IsDiv    = i_Funct3[2];
        w_DivZero  = w_IsDiv & (i_Source2 == '0);
        w_Overflow = w_IsDiv & w_Signed2 & (i_Source1 == w_MinInt) & (i_Source2 == '1);
        o_Special  = w_DivZero | w_Overflow;

        // Special results are preloaded as {rem, quo} with sign flags cleared, so FIXUP passes them through.
        if (w_DivZero)
            w_AccLoad = {1'b0, i_Source1, DIV_ZERO_QUOTIENT};
        else
            w_AccLoad = {{(XLEN+1){1'b0}}, w_MinInt};

        w_MulSum  = r_Acc[2*XLEN:XLEN] + (r_Acc[0] ? {1'b0, r_Opnd} : '0);
        w_MulNext = {1'b0, w_MulSum, r_Acc[XLEN-1:1]};
        w_DivDiff = r_Acc[2*XLEN-1:XLEN-1] - {1'b0, r_Opnd};
        w_DivNext = w_DivDiff[XLEN] ? {r_Acc[2*XLEN-1:0], 1'b0}
                                    : {w_DivDiff, r_Acc[XLEN-2:0], 1'b1};

        w_Prod = r_NegQ ? -r_Acc[2*XLEN-1:0] : r_Acc[2*XLEN-1:0];
        w_Quo  = r_NegQ ? -r_Acc[XLEN-1:0] : r_Acc[XLEN-1:0];
        w_Rem  = r_NegR ? -r_Acc[2*XLEN-1:XLEN] : r_Acc[2*XLEN-1:XLEN];

        case (r_Op)
            OP_MUL:                       w_Result = w_Prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_Result = w_Prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_Result = w_Quo;
            default:                      w_Result = w_Rem;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Op     <= OP_MUL;
            r_Acc    <= '0;
            r_Opnd   <= '0;
            r_NegQ   <= 1'b0;
            r_NegR   <= 1'b0;
            r_Result <= '0;
        end else begin
            if (i_Load) begin
                r_Op <= w_Op;
                if (i_LoadSpecial) begin
                    r_Acc  <= w_AccLoad;
                    r_NegQ <= 1'b0;
                    r_NegR <= 1'b0;
                end else begin
                    r_Acc  <= {{(XLEN+1){1'b0}}, (w_IsDiv ? w_Mag1 : w_Mag2)};
                    r_Opnd <= w_IsDiv ? w_Mag2 : w_Mag1;
                    // A zero divisor yields all-ones quotient regardless of operand signs.
                    r_NegQ <= (w_Neg1 ^ w_Neg2) & ~w_DivZero;
                    r_NegR <= w_Neg1;
                end
            end else if (i_Step) begin
                r_Acc <= r_Op[2] ? w_DivNext : w_MulNext;
            end
            if (i_Fixup)
                r_Result <= w_Result;
        end
    end

    assign o_Result = r_Result;

endmodule

// File: rtl/stage_execution_muldiv_ctrl.sv
// EX-stage RV32M sequencer: control FSM and iteration counter around muldiv_datapath.
module stage_execution_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            i_Clock,
    input  logic            i_Reset_n,
    input  logic            i_Start,
    input  logic [2:0]      i_Funct3,
    input  logic [XLEN-1:0] i_Source1,
    input  logic [XLEN-1:0] i_Source2,
    input  logic            i_Flush,
    output logic            o_Stall,
    output logic            o_Busy,
    output logic            o_Done,
    output logic [XLEN-1:0] o_Result
);

    localparam int unsigned CNT_W = $clog2(MULDIV_ITERATIONS);

    MulDivState_t     r_State, w_NextState;
    logic [CNT_W-1:0] r_Count;
    logic             w_Load, w_Step, w_Fixup, w_Special;

    assign w_Load  = (r_State == LOAD) & ~i_Flush;
    assign w_Step  = ((r_State == MUL) | (r_State == DIV)) & ~i_Flush;
    assign w_Fixup = (r_State == FIXUP) & ~i_Flush;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_State <= IDLE;
            r_Count <= '0;
        end else begin
            r_State <= w_NextState;
            if (w_Load)
                r_Count <= CNT_W'(MULDIV_ITERATIONS - 1);
            else if (w_Step)
                r_Count <= r_Count - 1'b1;
        end
    end

    always_comb begin
        w_NextState = r_State;
        case (r_State)
            IDLE:  if (i_Start) w_NextState = LOAD;
            // Early-out results are preloaded and still pass through FIXUP to reach o_Result.
            LOAD:  if (EARLY_OUT && w_Special) w_NextState = FIXUP;
                   else                        w_NextState = i_Funct3[2] ? DIV : MUL;
            MUL,
            DIV:   if (r_Count == '0) w_NextState = FIXUP;
            FIXUP: w_NextState = DONE;
            DONE:  w_NextState = IDLE;
            default: w_NextState = IDLE;
        endcase
        if (i_Flush)
            w_NextState = IDLE;
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .i_Clock       (i_Clock),
        .i_Reset_n     (i_Reset_n),
        .i_Load        (w_Load),
        .i_LoadSpecial (EARLY_OUT & w_Special),
        .i_Step        (w_Step),
        .i_Fixup       (w_Fixup),
        .i_Funct3      (i_Funct3),
        .i_Source1     (i_Source1),
        .i_Source2     (i_Source2),
        .o_Special     (w_Special),
        .o_Result      (o_Result)
    );

    assign o_Stall = i_Start & (r_State != DONE);
    assign o_Busy  = (r_State != IDLE);
    assign o_Done  = (r_State == DONE) & ~i_Flush;

endmodule

// File: tb/tb_stage_execution_muldiv_ctrl.sv
// Directed bench: one early-out and one fully iterative instance, table vectors plus corner sequences.
module tb_stage_execution_muldiv_ctrl;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    localparam int NVEC = 20;

    logic        clk = 1'b0;
    logic        rst_n, start_eo, start_it, flush;
    logic [2:0]  f3;
    logic [31:0] s1, s2;
    logic        stall_eo, busy_eo, done_eo, stall_it, busy_it, done_it;
    logic [31:0] result_eo, result_it;
    logic        m_stall, m_busy, m_done;
    logic [31:0] m_result;
    bit          sel;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        vecs [NVEC];

    always #5 clk = ~clk;

    stage_execution_muldiv_ctrl #(.XLEN(32), .EARLY_OUT(1'b1)) dut_eo (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start_eo), .i_Funct3(f3),
        .i_Source1(s1), .i_Source2(s2), .i_Flush(flush),
        .o_Stall(stall_eo), .o_Busy(busy_eo), .o_Done(done_eo), .o_Result(result_eo)
    );

    stage_execution_muldiv_ctrl #(.XLEN(32), .EARLY_OUT(1'b0)) dut_it (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(start_it), .i_Funct3(f3),
        .i_Source1(s1), .i_Source2(s2), .i_Flush(flush),
        .o_Stall(stall_it), .o_Busy(busy_it), .o_Done(done_it), .o_Result(result_it)
    );

    always_comb begin
        m_stall  = sel ? stall_eo  : stall_it;
        m_busy   = sel ? busy_eo   : busy_it;
        m_done   = sel ? done_eo   : done_it;
        m_result = sel ? result_eo : result_it;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (busy_eo && !done_eo && !start_eo && !flush)
                $error("FAIL protocol: i_Start dropped mid-op on early-out instance");
            if (busy_it && !done_it && !start_it && !flush)
                $error("FAIL protocol: i_Start dropped mid-op on iterative instance");
        end
    end

    task automatic chk(input string what, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] sel=%0d: got %h expected %h", what, idx, sel, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start_eo = v;
        else     start_it = v;
    endtask

    // Called #1 after a rising edge; returns cycles from the accept-1 cycle (cycle 0) to o_Done.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls);
        f3 = op; s1 = a; s2 = b;
        set_start(1'b1);
        #1;
        stalls = m_stall ? 1 : 0;
        lat    = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (m_done) begin
                lat = c;
                break;
            end
            if (m_stall) stalls++;
        end
        res = m_result;
    endtask

    task automatic finish_op(input int idx, input logic [31:0] exp);
        chk("stall_in_done", idx, {31'b0, m_stall}, 32'd0);
        @(posedge clk); #1;
        set_start(1'b0);
        chk("done_pulse", idx, {31'b0, m_done}, 32'd0);
        chk("busy_after", idx, {31'b0, m_busy}, 32'd0);
        chk("result_held", idx, m_result, exp);
    endtask

    initial begin
        logic [31:0] res;
        int          lat, stalls, exp_lat;
        bit          seen;

        vecs[0]  = '{3'd0, 32'd7,         32'd6,         32'd42,        1'b0};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  1'b0};
        vecs[2]  = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0};
        vecs[4]  = '{3'd0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  1'b0};
        vecs[5]  = '{3'd1, 32'h80000000,  32'h80000000,  32'h40000000,  1'b0};
        vecs[6]  = '{3'd3, 32'h80000000,  32'd2,         32'h00000001,  1'b0};
        vecs[7]  = '{3'd4, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0};
        vecs[8]  = '{3'd6, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  1'b0};
        vecs[9]  = '{3'd5, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  1'b0};
        vecs[10] = '{3'd4, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  1'b0};
        vecs[11] = '{3'd6, 32'd7,         32'hFFFFFFFE,  32'h00000001,  1'b0};
        vecs[12] = '{3'd5, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  1'b0};
        vecs[13] = '{3'd7, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0};
        vecs[14] = '{3'd4, 32'd5,         32'd0,         32'hFFFFFFFF,  1'b1};
        vecs[15] = '{3'd7, 32'd5,         32'd0,         32'd5,         1'b1};
        vecs[16] = '{3'd4, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b1};
        vecs[17] = '{3'd6, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  1'b1};
        vecs[18] = '{3'd4, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  1'b1};
        vecs[19] = '{3'd6, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  1'b1};

        rst_n = 1'b0; start_eo = 1'b0; start_it = 1'b0; flush = 1'b0;
        f3 = 3'd0; s1 = '0; s2 = '0; sel = 1'b1;
        #12;
        chk("reset_busy_eo",   0, {31'b0, busy_eo},  32'd0);
        chk("reset_done_eo",   0, {31'b0, done_eo},  32'd0);
        chk("reset_stall_eo",  0, {31'b0, stall_eo}, 32'd0);
        chk("reset_result_eo", 0, result_eo,         32'd0);
        chk("reset_busy_it",   0, {31'b0, busy_it},  32'd0);
        chk("reset_result_it", 0, result_it,         32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            for (int s = 0; s < 2; s++) begin
                sel     = (s == 1);
                exp_lat = (sel && vecs[i].special) ? 3 : 35;
                run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, stalls);
                chk("result",  i, res, vecs[i].exp);
                chk("latency", i, lat, exp_lat);
                chk("stalls",  i, stalls, exp_lat);
                finish_op(i, vecs[i].exp);
            end
        end

        // Back-to-back DIVU then REMU with i_Start held through DONE.
        sel = 1'b1;
        run_op(3'd5, 32'd100, 32'd7, res, lat, stalls);
        chk("b2b_divu", 100, res, 32'd14);
        chk("b2b_divu_lat", 100, lat, 35);
        run_op(3'd7, 32'd100, 32'd7, res, lat, stalls);
        chk("b2b_remu", 101, res, 32'd2);
        chk("b2b_remu_lat", 101, lat, 36);
        chk("b2b_remu_stalls", 101, stalls, 35);
        finish_op(101, 32'd2);

        // Flush at iteration 10 of a MUL: no done, result keeps previous value.
        f3 = 3'd0; s1 = 32'd5; s2 = 32'd5;
        set_start(1'b1);
        repeat (12) begin @(posedge clk); #1; end
        chk("flush_busy_before", 102, {31'b0, m_busy}, 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_no_done_now", 102, {31'b0, m_done}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        set_start(1'b0);
        chk("flush_idle", 102, {31'b0, m_busy}, 32'd0);
        chk("flush_result", 102, m_result, 32'd2);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (m_done) seen = 1'b1; end
        chk("flush_no_done", 102, {31'b0, seen}, 32'd0);
        run_op(3'd0, 32'd3, 32'd3, res, lat, stalls);
        chk("after_flush_mul", 103, res, 32'd9);
        chk("after_flush_lat", 103, lat, 35);
        finish_op(103, 32'd9);

        // Flush together with Start in IDLE is not accepted.
        flush = 1'b1;
        set_start(1'b1);
        @(posedge clk); #1;
        chk("flush_start_idle", 104, {31'b0, m_busy}, 32'd0);
        flush = 1'b0;
        set_start(1'b0);
        @(posedge clk); #1;
        chk("flush_start_idle2", 104, {31'b0, m_busy}, 32'd0);

        // Asynchronous reset mid-DIV on the iterative instance.
        sel = 1'b0;
        f3 = 3'd4; s1 = 32'd1000; s2 = 32'd3;
        set_start(1'b1);
        repeat (15) begin @(posedge clk); #1; end
        chk("rst_busy_before", 105, {31'b0, m_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 105, {31'b0, m_busy}, 32'd0);
        chk("rst_done", 105, {31'b0, m_done}, 32'd0);
        chk("rst_result", 105, m_result, 32'd0);
        chk("rst_stall_follows_start", 105, {31'b0, m_stall}, 32'd1);
        set_start(1'b0);
        #1;
        chk("rst_stall", 105, {31'b0, m_stall}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'd5, 32'd100, 32'd7, res, lat, stalls);
        chk("post_rst_divu", 106, res, 32'd14);
        finish_op(106, 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
